// File: rtl/user_flash_pe_ctrl_pkg.sv
// Shared definitions for the GW1NR-9 user flash: geometry, op/state encodings,
// and the microsecond-to-cycle conversion used for every flash timing phase.
package user_flash_pkg;

  localparam int unsigned ROW_W     = 9;
  localparam int unsigned COL_W     = 6;
  localparam int unsigned ADDR_W    = ROW_W + COL_W;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_ROWS  = 304;
  localparam int unsigned ROW_WORDS = 64;
  localparam int unsigned CNT_W     = 25;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_PROG  = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_PULSE,
    ST_HOLD,
    ST_RECOVER,
    ST_DONE
  } state_e;

  // ceil(freq * us / 1e6), never less than one cycle
  function automatic longint unsigned us_to_cycles(input longint unsigned freq,
                                                   input longint unsigned us);
    longint unsigned c;
    c = (freq * us + 64'd999_999) / 64'd1_000_000;
    return (c == 64'd0) ? 64'd1 : c;
  endfunction

endpackage

// File: rtl/user_flash_pe_ctrl_if.sv
// Command/status channel between the control register block (master) and the
// program/erase sequencer (slave).
interface user_flash_pe_ctrl_if;
  import user_flash_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [WORD_W-1:0]   cmd_data;
  logic                busy;
  logic                done;
  logic                err;
  logic                inval;
  logic [ROW_W-1:0]    inval_row;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, busy, done, err, inval, inval_row
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, busy, done, err, inval, inval_row
  );

endinterface

// File: rtl/user_flash_pe_ctrl_timer.sv
// Loadable down-counter that times each flash phase; holds at zero.
module flash_phase_timer
  import user_flash_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/user_flash_pe_ctrl.sv
// Program/erase sequencer for the GW1NR-9 user flash. Pins are decoded from the
// current state and registered, so they lag the state register by one cycle.
module user_flash_pe_ctrl
  import user_flash_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 27_000_000,
  parameter int unsigned T_NVS_US   = 5,
  parameter int unsigned T_PGS_US   = 10,
  parameter int unsigned T_PROG_US  = 16,
  parameter int unsigned T_ERASE_US = 120_000,
  parameter int unsigned T_NVH_US   = 5,
  parameter int unsigned T_RCV_US   = 10
) (
  input  logic               clk,
  input  logic               reset,
  user_flash_pe_ctrl_if.slave cmd,
  output logic               xe,
  output logic               ye,
  output logic               se,
  output logic               prog,
  output logic               erase,
  output logic               nvstr,
  output logic [ROW_W-1:0]   xadr,
  output logic [COL_W-1:0]   yadr,
  output logic [WORD_W-1:0]  din
);

  localparam longint unsigned N_NVS   = us_to_cycles(64'(CLK_FREQ), 64'(T_NVS_US));
  localparam longint unsigned N_PGS   = us_to_cycles(64'(CLK_FREQ), 64'(T_PGS_US));
  localparam longint unsigned N_PROG  = us_to_cycles(64'(CLK_FREQ), 64'(T_PROG_US));
  localparam longint unsigned N_ERASE = us_to_cycles(64'(CLK_FREQ), 64'(T_ERASE_US));
  localparam longint unsigned N_NVH   = us_to_cycles(64'(CLK_FREQ), 64'(T_NVH_US));
  localparam longint unsigned N_RCV   = us_to_cycles(64'(CLK_FREQ), 64'(T_RCV_US));
  localparam longint unsigned N_LIMIT = 64'd1 << CNT_W;

  if (N_NVS >= N_LIMIT || N_PGS >= N_LIMIT || N_PROG >= N_LIMIT ||
      N_ERASE >= N_LIMIT || N_NVH >= N_LIMIT || N_RCV >= N_LIMIT) begin : g_cnt_overflow
    $error("flash phase length does not fit the phase counter");
  end

  localparam logic [CNT_W-1:0] L_NVS   = CNT_W'(N_NVS - 64'd1);
  localparam logic [CNT_W-1:0] L_PGS   = CNT_W'(N_PGS - 64'd1);
  localparam logic [CNT_W-1:0] L_PROG  = CNT_W'(N_PROG - 64'd1);
  localparam logic [CNT_W-1:0] L_ERASE = CNT_W'(N_ERASE - 64'd1);
  localparam logic [CNT_W-1:0] L_NVH   = CNT_W'(N_NVH - 64'd1);
  localparam logic [CNT_W-1:0] L_RCV   = CNT_W'(N_RCV - 64'd1);

  state_e             state_q, state_d;
  logic               is_erase_q, is_erase_d;
  logic               fail_q, fail_d;
  logic               tmr_load, tmr_zero;
  logic [CNT_W-1:0]   tmr_value;
  op_e                op_in;
  logic               accept;

  logic               xe_q, xe_d, ye_q, ye_d, prog_q, prog_d;
  logic               erase_q, erase_d, nvstr_q, nvstr_d;
  logic [ROW_W-1:0]   xadr_q, xadr_d, inval_row_q, inval_row_d;
  logic [COL_W-1:0]   yadr_q, yadr_d;
  logic [WORD_W-1:0]  din_q, din_d;
  logic               cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic               done_q, done_d, err_q, err_d, inval_q, inval_d;

  flash_phase_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  assign op_in  = op_e'(cmd.cmd_op);
  assign accept = cmd.cmd_valid && cmd_ready_q;

  always_comb begin
    state_d    = state_q;
    is_erase_d = is_erase_q;
    fail_d     = fail_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    xadr_d     = xadr_q;
    yadr_d     = yadr_q;
    din_d      = din_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_in == OP_PROG || op_in == OP_ERASE) begin
            state_d    = ST_SETUP;
            tmr_load   = 1'b1;
            tmr_value  = L_NVS;
            is_erase_d = (op_in == OP_ERASE);
            fail_d     = 1'b0;
            xadr_d     = cmd.cmd_addr[ADDR_W-1:COL_W];
            yadr_d     = (op_in == OP_ERASE) ? '0 : cmd.cmd_addr[COL_W-1:0];
            din_d      = (op_in == OP_ERASE) ? '0 : cmd.cmd_data;
          end else begin
            state_d = ST_DONE;
            fail_d  = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d   = ST_STROBE;
          tmr_load  = 1'b1;
          tmr_value = is_erase_q ? L_ERASE : L_PGS;
        end
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          state_d   = is_erase_q ? ST_HOLD : ST_PULSE;
          tmr_load  = 1'b1;
          tmr_value = is_erase_q ? L_NVH : L_PROG;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_d   = ST_HOLD;
          tmr_load  = 1'b1;
          tmr_value = L_NVH;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_d   = ST_RECOVER;
          tmr_load  = 1'b1;
          tmr_value = L_RCV;
        end
      end
      ST_RECOVER: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Pins follow the state one cycle late, giving the accept-to-pin latency of one.
    xe_d        = state_q inside {ST_SETUP, ST_STROBE, ST_PULSE, ST_HOLD};
    prog_d      = !is_erase_q && (state_q inside {ST_SETUP, ST_STROBE, ST_PULSE});
    erase_d     = is_erase_q && (state_q inside {ST_SETUP, ST_STROBE});
    nvstr_d     = state_q inside {ST_STROBE, ST_PULSE, ST_HOLD};
    ye_d        = (state_q == ST_PULSE);
    done_d      = (state_q == ST_DONE);
    err_d       = done_d && fail_q;
    inval_d     = done_d && !fail_q;
    inval_row_d = inval_d ? xadr_q : inval_row_q;
    busy_d      = (state_q != ST_IDLE);
    cmd_ready_d = (state_q == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      is_erase_q  <= 1'b0;
      fail_q      <= 1'b0;
      xe_q        <= 1'b0;
      ye_q        <= 1'b0;
      prog_q      <= 1'b0;
      erase_q     <= 1'b0;
      nvstr_q     <= 1'b0;
      xadr_q      <= '0;
      yadr_q      <= '0;
      din_q       <= '0;
      inval_row_q <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      inval_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_erase_q  <= is_erase_d;
      fail_q      <= fail_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
      prog_q      <= prog_d;
      erase_q     <= erase_d;
      nvstr_q     <= nvstr_d;
      xadr_q      <= xadr_d;
      yadr_q      <= yadr_d;
      din_q       <= din_d;
      inval_row_q <= inval_row_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      inval_q     <= inval_d;
    end
  end

  assign xe            = xe_q;
  assign ye            = ye_q;
  assign se            = 1'b0;
  assign prog          = prog_q;
  assign erase         = erase_q;
  assign nvstr         = nvstr_q;
  assign xadr          = xadr_q;
  assign yadr          = yadr_q;
  assign din           = din_q;
  assign cmd.cmd_ready = cmd_ready_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign cmd.inval     = inval_q;
  assign cmd.inval_row = inval_row_q;

endmodule

// File: doc/user_flash_pe_ctrl.md
# user_flash_pe_ctrl

Program/erase sequencer for the GW1NR-9 user flash (304 rows × 64 words × 32 bit). It accepts single-word program and single-row erase commands from a memory-mapped control register block. It drives the flash primitive's XE/YE/SE/PROG/ERASE/NVSTR pins with the required setup, hold and pulse times, and pulses a row-invalidate to the read cache on completion. While `busy`=1, the top level routes the flash pins from this block instead of the read cache.

## Interface
- `CLK_FREQ`, 27_000_000: clock frequency in Hz.
- `T_NVS_US`, 5: PROG/ERASE to NVSTR setup.
- `T_PGS_US`, 10: NVSTR to first YE (program).
- `T_PROG_US`, 16: YE program pulse width.
- `T_ERASE_US`, 120_000: erase pulse (NVSTR high, ERASE high).
- `T_NVH_US`, 5: PROG/ERASE low to NVSTR low.
- `T_RCV_US`, 10: recovery before the next access.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high in IDLE only.
- `cmd_op` in 2: 01 = program word, 10 = erase row, 00/11 = illegal.
- `cmd_addr` in 15: word address; [14:6] row, [5:0] column.
- `cmd_data` in 32: program data.
- `busy` out 1: high from accept through DONE inclusive.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 = illegal op.
- `inval` out 1: one-cycle pulse with `done` on a successful op.
- `inval_row` out 9: row to drop from the cache; valid with `inval`.
- `xe`, `ye`, `se`, `prog`, `erase`, `nvstr` out 1 each: flash controls.
- `xadr` out 9, `yadr` out 6, `din` out 32: flash address and data.

## Operation
- Phase length N = max(1, ceil(CLK_FREQ × T_us / 1e6)) cycles, computed at elaboration.
- Address and data are latched at accept (`cmd_valid` & `cmd_ready`).
- Erase: `yadr`=0 and `xadr`=row.
- Program: `xadr`/`yadr` are taken from `cmd_addr` and `din`=`cmd_data`.
- `se` is always 0.
- States and outputs:
  - IDLE: all flash pins 0, `cmd_ready`=1. Legal accept → SETUP. Illegal accept → DONE with `err`=1 and no pin activity.
  - SETUP: `xe`=1 and `prog` or `erase`=1, held for N_NVS cycles → STROBE.
  - STROBE: adds `nvstr`=1, held for N_PGS cycles (program) or N_ERASE cycles (erase). Program → PULSE; erase → HOLD.
  - PULSE (program only): adds `ye`=1 for N_PROG cycles → HOLD.
  - HOLD: `ye`=0, `prog`=`erase`=0, `xe`=1, `nvstr`=1, held for N_NVH cycles → RECOVER.
  - RECOVER: all pins 0, held for N_RCV cycles → DONE.
  - DONE: `done`=1 for one cycle; `inval`=1 unless `err`; → IDLE.
- Phase counter: loaded with N-1 on state entry and decremented each cycle. The transition occurs in the cycle the counter reads 0.
- Counter width is 25 bits, enough for 120 ms at 200 MHz. Elaboration fails if any N ≥ 2^25.
- Pins are registered outputs. No pin changes in the same cycle as another pin's transition edge except the transitions listed above.
- `cmd_valid` while busy is ignored (not queued). The requester holds it until `cmd_ready`.
- Reset mid-operation: all outputs 0 on the next edge, state IDLE, no `done`. The flash row content is then undefined; software re-erases it.

## Timing
- Reset values: `cmd_ready`=1; `busy`, `done`, `err`, `inval`, every flash pin, `xadr`, `yadr`, `din`, `inval_row` = 0.
- Accept at edge k: `busy`=1 and SETUP pins asserted from edge k+1.
- Program latency, accept to `done` high: 1 + N_NVS + N_PGS + N_PROG + N_NVH + N_RCV cycles. With CLK_FREQ=1 MHz this is 47.
- Erase latency: 1 + N_NVS + N_ERASE + N_NVH + N_RCV cycles. With CLK_FREQ=1 MHz this is 120_021.
- Illegal op: `done` and `err` high at edge k+1, `cmd_ready` again at k+2.
- Back-to-back: the next accept is possible in the cycle after DONE.

## Structure
- Package `user_flash_pkg` holds:
  - op encodings;
  - state encodings;
  - the `us_to_cycles(freq, us)` function;
  - row/column width constants (9/6) and the array geometry, shared with the read cache.
- Sub-module `flash_phase_timer` is a loadable 25-bit down-counter with `load`, `value` and a `zero` flag. The FSM stays in `user_flash_pe_ctrl`.

## Test plan
All scenarios run with CLK_FREQ=1_000_000.
- Program, op=01, addr=0x1A5, data=0xDEADBEEF:
  - `done` at 47 cycles after accept;
  - `xadr`=6, `yadr`=0x25, `din`=0xDEADBEEF throughout;
  - `ye` high exactly 16 cycles, `nvstr` high 31 cycles;
  - `inval`, `inval_row`=6.
- Erase, op=10, addr=0x7FFF: `erase` high 120_005 cycles, `ye` never high, `xadr`=0x1FF, `done` at 120_021.
- Illegal op=11: `done`=`err`=1 one cycle after accept, `inval`=0, all pins stay 0.
- `cmd_valid` held during a program with a second command: it is ignored until IDLE, then accepted the cycle after `done`.
- Reset asserted in PULSE: the next edge shows all pins 0, `cmd_ready`=1, and no `done` pulse.
- Pin-order checker over randomized legal commands:
  - `nvstr` never rises without `prog`/`erase` high N_NVS cycles earlier;
  - `ye` only in PULSE;
  - `se` always 0.
